// File: rtl/vc_buffer_bank_if.sv
// vc_buffer_bank_if: write/read port and status bundle for vc_buffer_bank.
// The credit return signals exist only when VCBUF_CREDIT_EN is defined.
interface vc_buffer_bank_if #(
   parameter int DATA_W = 10,
   parameter int DEPTH  = 32,
   parameter int NUM_VC = 4
);
   localparam int AW = $clog2(DEPTH);
   localparam int VW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

   logic                     wr_en;
   logic [VW-1:0]            wr_vc;
   logic [DATA_W-1:0]        wr_data;
   logic                     rd_en;
   logic [VW-1:0]            rd_vc;
   logic [DATA_W-1:0]        rd_data;
   logic [NUM_VC-1:0]        full;
   logic [NUM_VC-1:0]        empty;
   logic [NUM_VC*(AW+1)-1:0] ocup;
   logic                     error;
   logic                     err_sticky;
`ifdef VCBUF_CREDIT_EN
   logic                     credit_valid;
   logic [VW-1:0]            credit_vc;

   modport master (
      output wr_en, wr_vc, wr_data, rd_en, rd_vc,
      input  rd_data, full, empty, ocup, error, err_sticky, credit_valid, credit_vc
   );
   modport slave (
      input  wr_en, wr_vc, wr_data, rd_en, rd_vc,
      output rd_data, full, empty, ocup, error, err_sticky, credit_valid, credit_vc
   );
`else
   modport master (
      output wr_en, wr_vc, wr_data, rd_en, rd_vc,
      input  rd_data, full, empty, ocup, error, err_sticky
   );
   modport slave (
      input  wr_en, wr_vc, wr_data, rd_en, rd_vc,
      output rd_data, full, empty, ocup, error, err_sticky
   );
`endif
endinterface

// File: rtl/vc_buffer_bank.sv
// vc_buffer_bank: NUM_VC independent FIFOs of DEPTH flits sharing one
// write port and one read port. Head flit of rd_vc is read combinationally.
// Optional feature macro: VCBUF_CREDIT_EN (one-cycle credit pulse per pop).
module vc_buffer_bank #(
   parameter int DATA_W = 10,
   parameter int DEPTH  = 32,
   parameter int NUM_VC = 4
) (
   input  logic              clk,
   input  logic              reset,
   vc_buffer_bank_if.slave   bus
);
   localparam int AW    = $clog2(DEPTH);
   localparam int VW    = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
   localparam int PW    = AW + 1;
   localparam int WORDS = NUM_VC * DEPTH;

   // Flit storage; VC v slot s sits at v*DEPTH+s, i.e. {v, s}.
   logic [DATA_W-1:0]        mem [WORDS];

   logic [NUM_VC-1:0][AW:0]  wp_vec;
   logic [NUM_VC-1:0][AW:0]  rp_vec;
   logic [NUM_VC-1:0]        full_vec;
   logic [NUM_VC-1:0]        empty_vec;

   logic                     wr_in_range;
   logic                     rd_in_range;
   logic [VW-1:0]            wr_idx;
   logic [VW-1:0]            rd_idx;
   logic                     wr_blocked;
   logic                     rd_blocked;
   logic                     push_ok;
   logic                     pop_ok;
   logic [VW+AW-1:0]         wr_addr;
   logic [VW+AW-1:0]         rd_addr;
   logic                     err_sticky_reg;

   // Out-of-range VC numbers behave as a full (write) / empty (read) VC;
   // the index is forced to 0 so no array is addressed past its end.
   assign wr_in_range = (32'(bus.wr_vc) < NUM_VC);
   assign rd_in_range = (32'(bus.rd_vc) < NUM_VC);
   assign wr_idx      = wr_in_range ? bus.wr_vc : '0;
   assign rd_idx      = rd_in_range ? bus.rd_vc : '0;

   // Acceptance looks only at registered flags: no bypass either way.
   assign wr_blocked  = !wr_in_range || full_vec[wr_idx];
   assign rd_blocked  = !rd_in_range || empty_vec[rd_idx];
   assign push_ok     = bus.wr_en && !wr_blocked;
   assign pop_ok      = bus.rd_en && !rd_blocked;
   assign bus.error   = (bus.wr_en && wr_blocked) || (bus.rd_en && rd_blocked);

   assign wr_addr     = {wr_idx, wp_vec[wr_idx][AW-1:0]};
   assign rd_addr     = {rd_idx, rp_vec[rd_idx][AW-1:0]};

   // Storage write; contents are intentionally left untouched by reset.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_addr] <= bus.wr_data;
      end
   end

   // Head of the selected VC; forced to zero when that VC is empty so stale
   // storage is never exposed (including after reset).
   assign bus.rd_data = rd_blocked ? '0 : mem[rd_addr];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_VC; gi++) begin : g_vc
         logic [AW:0] wp_reg;
         logic [AW:0] rp_reg;

         // Per-VC pointer pair; the MSB is the wrap bit.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               wp_reg <= '0;
               rp_reg <= '0;
            end else begin
               if (push_ok && (wr_idx == VW'(gi))) begin
                  wp_reg <= wp_reg + 1'b1;
               end
               if (pop_ok && (rd_idx == VW'(gi))) begin
                  rp_reg <= rp_reg + 1'b1;
               end
            end
         end

         assign wp_vec[gi]            = wp_reg;
         assign rp_vec[gi]            = rp_reg;
         assign empty_vec[gi]         = (wp_reg == rp_reg);
         assign full_vec[gi]          = (wp_reg[AW-1:0] == rp_reg[AW-1:0]) &&
                                        (wp_reg[AW] != rp_reg[AW]);
         assign bus.ocup[gi*PW +: PW] = wp_reg - rp_reg;
      end
   endgenerate

   assign bus.full  = full_vec;
   assign bus.empty = empty_vec;

   // Sticky error: any illegal push/pop latches until reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_sticky_reg <= 1'b0;
      end else if (bus.error) begin
         err_sticky_reg <= 1'b1;
      end
   end

   assign bus.err_sticky = err_sticky_reg;

`ifdef VCBUF_CREDIT_EN
   logic          credit_valid_reg;
   logic [VW-1:0] credit_vc_reg;

   // One credit pulse in the cycle after each accepted pop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         credit_valid_reg <= 1'b0;
         credit_vc_reg    <= '0;
      end else begin
         credit_valid_reg <= pop_ok;
         if (pop_ok) begin
            credit_vc_reg <= rd_idx;
         end
      end
   end

   assign bus.credit_valid = credit_valid_reg;
   assign bus.credit_vc    = credit_vc_reg;
`endif

endmodule

// File: tb/tb_vc_buffer_bank.sv
// tb_vc_buffer_bank: scoreboard bench for vc_buffer_bank (4 VCs x 32 flits).
// Stimulus pushes per-cycle expectations from a queue-based model; a
// negedge monitor pops and compares them against the DUT outputs.
module tb_vc_buffer_bank;
   localparam int DATA_W = 10;
   localparam int DEPTH  = 32;
   localparam int NUM_VC = 4;
   localparam int AW     = 5;
   localparam int PW     = AW + 1;

   typedef struct {
      logic                     we;
      int                       wv;
      logic [DATA_W-1:0]        wd;
      logic                     re;
      int                       rv;
      logic                     in_reset;
      logic [DATA_W-1:0]        rd_data;
      logic                     error;
      logic [NUM_VC-1:0]        empty;
      logic [NUM_VC-1:0]        full;
      logic [NUM_VC*PW-1:0]     ocup;
      logic                     sticky;
      logic                     cvalid;
      logic [1:0]               cvc;
   } exp_t;

   logic clk;
   logic reset;

   vc_buffer_bank_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_VC(NUM_VC)) bus ();

   vc_buffer_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_VC(NUM_VC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: one plain FIFO queue per VC.
   logic [DATA_W-1:0] model_q [NUM_VC][$];
   logic              m_sticky;
   logic              m_cvalid;
   logic [1:0]        m_cvc;

   exp_t exp_q [$];
   int   checks;
   int   errors;
   int   txn;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s txn=%0d actual=%h expected=%h", name, txn, act, exp);
      end
   endtask

   function automatic exp_t snapshot(input logic we, input int wv, input logic [DATA_W-1:0] wd,
                                     input logic re, input int rv, input logic in_rst);
      exp_t e;
      logic rd_empty, wr_full;
      e.we = we; e.wv = wv; e.wd = wd; e.re = re; e.rv = rv; e.in_reset = in_rst;
      rd_empty  = (rv >= NUM_VC) || (model_q[rv].size() == 0);
      wr_full   = (wv >= NUM_VC) || (model_q[wv].size() == DEPTH);
      e.rd_data = rd_empty ? '0 : model_q[rv][0];
      e.error   = (we && wr_full) || (re && rd_empty);
      for (int v = 0; v < NUM_VC; v++) begin
         e.empty[v]          = (model_q[v].size() == 0);
         e.full[v]           = (model_q[v].size() == DEPTH);
         e.ocup[v*PW +: PW]  = PW'(model_q[v].size());
      end
      e.sticky = m_sticky;
      e.cvalid = m_cvalid;
      e.cvc    = m_cvc;
      return e;
   endfunction

   task automatic model_reset();
      for (int v = 0; v < NUM_VC; v++) model_q[v].delete();
      m_sticky = 1'b0;
      m_cvalid = 1'b0;
      m_cvc    = 2'd0;
   endtask

   // One clock cycle of stimulus; the expectation is taken before the edge
   // and the model then advances to the post-edge state.
   task automatic step(input logic we, input int wv, input logic [DATA_W-1:0] wd,
                       input logic re, input int rv);
      exp_t e;
      logic wr_full, rd_empty;
      @(posedge clk);
      #1;
      reset       = 1'b0;
      bus.wr_en   = we;
      bus.wr_vc   = 2'(wv);
      bus.wr_data = wd;
      bus.rd_en   = re;
      bus.rd_vc   = 2'(rv);
      e = snapshot(we, wv, wd, re, rv, 1'b0);
      exp_q.push_back(e);
      wr_full  = (model_q[wv].size() == DEPTH);
      rd_empty = (model_q[rv].size() == 0);
      if (re && !rd_empty) void'(model_q[rv].pop_front());
      if (we && !wr_full) model_q[wv].push_back(wd);
      m_sticky = m_sticky | e.error;
      m_cvalid = re && !rd_empty;
      if (re && !rd_empty) m_cvc = 2'(rv);
   endtask

   // Asynchronous reset asserted mid-cycle; checked before any clock edge.
   task automatic apply_reset();
      @(posedge clk);
      #1;
      reset       = 1'b1;
      bus.wr_en   = 1'b0;
      bus.rd_en   = 1'b0;
      bus.wr_vc   = '0;
      bus.rd_vc   = '0;
      bus.wr_data = '0;
      model_reset();
      exp_q.push_back(snapshot(1'b0, 0, '0, 1'b0, 0, 1'b1));
   endtask

   // Monitor: compares the oldest outstanding expectation each negedge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            txn++;
            $display("txn %0d rst=%0d we=%0d wv=%0d wd=%h re=%0d rv=%0d rd_data=%h err=%0d ocup=%h",
                     txn, e.in_reset, e.we, e.wv, e.wd, e.re, e.rv, bus.rd_data, bus.error, bus.ocup);
            chk("rd_data",    32'(bus.rd_data),    32'(e.rd_data));
            chk("error",      32'(bus.error),      32'(e.error));
            chk("empty",      32'(bus.empty),      32'(e.empty));
            chk("full",       32'(bus.full),       32'(e.full));
            chk("ocup",       32'(bus.ocup),       32'(e.ocup));
            chk("err_sticky", 32'(bus.err_sticky), 32'(e.sticky));
`ifdef VCBUF_CREDIT_EN
            chk("credit_valid", 32'(bus.credit_valid), 32'(e.cvalid));
            if (e.cvalid || e.in_reset) chk("credit_vc", 32'(bus.credit_vc), 32'(e.cvc));
`endif
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog txn=%0d actual=timeout expected=finish", txn);
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks = 0;
      errors = 0;
      txn    = 0;
      reset       = 1'b1;
      bus.wr_en   = 1'b0;
      bus.rd_en   = 1'b0;
      bus.wr_vc   = '0;
      bus.rd_vc   = '0;
      bus.wr_data = '0;
      model_reset();

      // Reset state with idle inputs.
      apply_reset();
      step(0, 0, 0, 0, 0);

      // Fill VC2 to the brim, then one rejected push, then idle.
      for (int i = 0; i < 32; i++) step(1, 2, 10'(i), 0, 0);
      step(1, 2, 10'h3AA, 0, 0);
      step(0, 0, 0, 0, 2);

      // Interleaved pushes to VC0/VC3, then alternating pops.
      for (int i = 0; i < 8; i++) begin
         step(1, 0, 10'(32'h100 + i), 0, 0);
         step(1, 3, 10'(32'h300 + i), 0, 3);
      end
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 0, 1, 0);
         step(0, 0, 0, 1, 3);
      end

      // VC1 to 31 entries, then 40 cycles of simultaneous push+pop (wrap).
      for (int i = 0; i < 31; i++) step(1, 1, 10'(32'h080 + i), 0, 1);
      for (int i = 0; i < 40; i++) step(1, 1, 10'(32'h0C0 + i), 1, 1);

      // Pop from empty VC0 while pushing VC0: pop rejected, push accepted.
      step(1, 0, 10'h1EE, 1, 0);
      step(0, 0, 0, 0, 0);

      // Back-to-back pops of VC3 for credit pulses.
      step(1, 3, 10'h311, 0, 3);
      step(1, 3, 10'h312, 0, 3);
      step(0, 0, 0, 1, 3);
      step(0, 0, 0, 1, 3);
      step(0, 0, 0, 0, 3);
      step(0, 0, 0, 0, 3);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 9) < 6), int'($urandom_range(0, 3)), 10'($urandom),
              ($urandom_range(0, 9) < 5), int'($urandom_range(0, 3)));
      end

      // Reset in the middle of filling; contents must vanish at once.
      for (int i = 0; i < 10; i++) step(1, int'($urandom_range(0, 3)), 10'($urandom), 0, 0);
      apply_reset();
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, i);
      for (int i = 0; i < 150; i++) begin
         step(($urandom_range(0, 9) < 5), int'($urandom_range(0, 3)), 10'($urandom),
              ($urandom_range(0, 9) < 5), int'($urandom_range(0, 3)));
      end
      step(0, 0, 0, 0, 0);

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
